// File: rtl/acl_cfg_pkg.sv
// Shared definitions for the ADXL362 activity/inactivity configuration loader:
// FSM state type, register base addresses and threshold width.
package acl_cfg_pkg;

  localparam int THRESH_WIDTH = 11;
  localparam int SEQ_LEN      = 6;
  localparam logic [2:0] SEQ_LAST = 3'(SEQ_LEN - 1);

  // Each base address is the low byte of a two-register pair (0x20..0x26).
  localparam logic [7:0] ADDR_THRESH_ACT_L   = 8'h20;
  localparam logic [7:0] ADDR_THRESH_INACT_L = 8'h23;
  localparam logic [7:0] ADDR_TIME_INACT_L   = 8'h25;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } state_t;

  function automatic logic [15:0] clamp_u16(input logic [15:0] value,
                                            input logic [15:0] ceiling);
    return (value > ceiling) ? ceiling : value;
  endfunction

endpackage

// File: rtl/preset_change_detect.sv
// Remembers the previous preset enum and raises a sticky pending flag on any
// change; the flag starts set so the first preset loads right after reset.
module preset_change_detect (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] i_enum,
  input  logic       i_clear,
  output logic       o_pending
);

  logic [3:0] enum_prev_q, enum_prev_d;
  logic       pending_q, pending_d;
  logic       change;

  // A change arriving on the same cycle as the clear must not be lost.
  always_comb begin
    enum_prev_d = i_enum;
    change      = (i_enum != enum_prev_q);
    pending_d   = pending_q;
    if (i_clear) pending_d = 1'b0;
    if (change)  pending_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enum_prev_q <= 4'd0;
      pending_q   <= 1'b1;
    end else begin
      enum_prev_q <= enum_prev_d;
      pending_q   <= pending_d;
    end
  end

  assign o_pending = pending_q;

endmodule

// File: rtl/thresh_config_loader.sv
// Writes the selected threshold/timer preset into the ADXL362 activity and
// inactivity registers, one register per write-command handshake.
module thresh_config_loader
  import acl_cfg_pkg::*;
#(
  parameter logic [15:0] parm_thresh_max          = 16'd2047,
  parameter logic [7:0]  parm_addr_thresh_act_l   = ADDR_THRESH_ACT_L,
  parameter logic [7:0]  parm_addr_thresh_inact_l = ADDR_THRESH_INACT_L,
  parameter logic [7:0]  parm_addr_time_inact_l   = ADDR_TIME_INACT_L
) (
  input  logic        i_clk_20mhz,
  input  logic        i_rst_20mhz,
  input  logic [3:0]  i_value_enum,
  input  logic [15:0] i_value_thresh,
  input  logic [15:0] i_value_timer,
  output logic        o_wr_valid,
  input  logic        i_wr_ready,
  output logic [7:0]  o_wr_addr,
  output logic [7:0]  o_wr_data,
  input  logic        i_wr_done,
  output logic        o_busy,
  output logic        o_load_done,
  output logic [3:0]  o_loaded_enum,
  output logic        o_clamped
);

  state_t                  state_q, state_d;
  logic [2:0]              idx_q, idx_d;
  logic [3:0]              seq_enum_q, seq_enum_d;
  logic [THRESH_WIDTH-1:0] thresh_q, thresh_d;
  logic [15:0]             timer_q, timer_d;
  logic                    clamped_q, clamped_d;
  logic [3:0]              loaded_enum_q, loaded_enum_d;
  logic                    pending;
  logic                    pending_clear;
  logic [15:0]             thresh_clamped;
  logic                    unused_thresh_hi;

  preset_change_detect u_change_detect (
    .clk       (i_clk_20mhz),
    .rst       (i_rst_20mhz),
    .i_enum    (i_value_enum),
    .i_clear   (pending_clear),
    .o_pending (pending)
  );

  // The clamped value never exceeds the 11-bit register field, so the upper bits are dead.
  assign thresh_clamped   = clamp_u16(i_value_thresh, parm_thresh_max);
  assign unused_thresh_hi = ^thresh_clamped[15:THRESH_WIDTH];

  always_ff @(posedge i_clk_20mhz or posedge i_rst_20mhz) begin
    if (i_rst_20mhz) begin
      state_q       <= ST_IDLE;
      idx_q         <= 3'd0;
      seq_enum_q    <= 4'd0;
      thresh_q      <= '0;
      timer_q       <= 16'd0;
      clamped_q     <= 1'b0;
      loaded_enum_q <= 4'd0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      seq_enum_q    <= seq_enum_d;
      thresh_q      <= thresh_d;
      timer_q       <= timer_d;
      clamped_q     <= clamped_d;
      loaded_enum_q <= loaded_enum_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pending_clear = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pending) begin
          state_d       = ST_LATCH;
          pending_clear = 1'b1;
        end
      end
      ST_LATCH: state_d = ST_ISSUE;
      ST_ISSUE: begin
        if (i_wr_ready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (i_wr_done) state_d = (idx_q == SEQ_LAST) ? ST_DONE : ST_ISSUE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Sequence registers are snapshotted once so later preset changes cannot tear a sequence.
  always_comb begin
    idx_d         = idx_q;
    seq_enum_d    = seq_enum_q;
    thresh_d      = thresh_q;
    timer_d       = timer_q;
    clamped_d     = clamped_q;
    loaded_enum_d = loaded_enum_q;
    case (state_q)
      ST_LATCH: begin
        seq_enum_d = i_value_enum;
        thresh_d   = thresh_clamped[THRESH_WIDTH-1:0];
        timer_d    = i_value_timer;
        clamped_d  = (i_value_thresh > parm_thresh_max);
        idx_d      = 3'd0;
      end
      ST_WAIT: begin
        if (i_wr_done) begin
          if (idx_q == SEQ_LAST) loaded_enum_d = seq_enum_q;
          else                   idx_d         = idx_q + 3'd1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    o_wr_valid    = (state_q == ST_ISSUE);
    o_busy        = (state_q != ST_IDLE);
    o_load_done   = (state_q == ST_DONE);
    o_loaded_enum = loaded_enum_q;
    o_clamped     = clamped_q;
    o_wr_addr     = 8'd0;
    o_wr_data     = 8'd0;
    if (state_q == ST_ISSUE) begin
      case (idx_q)
        3'd0: begin
          o_wr_addr = parm_addr_thresh_act_l;
          o_wr_data = thresh_q[7:0];
        end
        3'd1: begin
          o_wr_addr = parm_addr_thresh_act_l + 8'd1;
          o_wr_data = 8'(thresh_q[THRESH_WIDTH-1:8]);
        end
        3'd2: begin
          o_wr_addr = parm_addr_thresh_inact_l;
          o_wr_data = thresh_q[7:0];
        end
        3'd3: begin
          o_wr_addr = parm_addr_thresh_inact_l + 8'd1;
          o_wr_data = 8'(thresh_q[THRESH_WIDTH-1:8]);
        end
        3'd4: begin
          o_wr_addr = parm_addr_time_inact_l;
          o_wr_data = timer_q[7:0];
        end
        3'd5: begin
          o_wr_addr = parm_addr_time_inact_l + 8'd1;
          o_wr_data = timer_q[15:8];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_thresh_config_loader.sv
// Self-checking bench for thresh_config_loader: table vectors, corner-case
// sequences and randomized presets against a behavioural register-write model.
module tb_thresh_config_loader;

  logic        clk;
  logic        rst;
  logic [3:0]  value_enum;
  logic [15:0] value_thresh;
  logic [15:0] value_timer;
  logic        wr_valid;
  logic        wr_ready;
  logic [7:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        resp_done;
  logic        spur_done;
  logic        wr_done;
  logic        busy;
  logic        load_done;
  logic [3:0]  loaded_enum;
  logic        clamped;

  typedef struct {
    logic [3:0]  en;
    logic [15:0] thresh;
    logic [15:0] timer;
    logic [47:0] exp_bytes;
    logic        exp_clamped;
  } vec_t;

  vec_t        vecs[6];
  logic [15:0] wr_log[$];
  int          done_delay;
  int          done_count;
  int          n_checks;
  int          n_fail;

  assign wr_done = resp_done | spur_done;

  thresh_config_loader dut (
    .i_clk_20mhz    (clk),
    .i_rst_20mhz    (rst),
    .i_value_enum   (value_enum),
    .i_value_thresh (value_thresh),
    .i_value_timer  (value_timer),
    .o_wr_valid     (wr_valid),
    .i_wr_ready     (wr_ready),
    .o_wr_addr      (wr_addr),
    .o_wr_data      (wr_data),
    .i_wr_done      (wr_done),
    .o_busy         (busy),
    .o_load_done    (load_done),
    .o_loaded_enum  (loaded_enum),
    .o_clamped      (clamped)
  );

  initial begin
    clk = 1'b0;
    forever #25 clk = ~clk;
  end

  // SPI driver stand-in: logs each accepted write, then pulses done.
  initial begin
    resp_done = 1'b0;
    forever begin
      @(negedge clk);
      resp_done = 1'b0;
      if (!rst && wr_valid && wr_ready) begin
        wr_log.push_back({wr_addr, wr_data});
        @(posedge clk);
        repeat (done_delay - 1) @(posedge clk);
        @(negedge clk);
        resp_done = 1'b1;
      end
    end
  end

  initial begin
    done_count = 0;
    forever begin
      @(negedge clk);
      if (load_done) done_count++;
    end
  end

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [47:0] modelBytes(input logic [15:0] th, input logic [15:0] tm);
    int t;
    int m;
    t = int'(th);
    if (t > 2047) t = 2047;
    m = int'(tm);
    return {8'(t % 256), 8'(t / 256), 8'(t % 256), 8'(t / 256), 8'(m % 256), 8'(m / 256)};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] en, input logic [15:0] th, input logic [15:0] tm);
    @(negedge clk);
    value_enum   = en;
    value_thresh = th;
    value_timer  = tm;
  endtask

  task automatic waitLoadDone(input string name, input int max_cycles);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < max_cycles && !seen; i++) begin
      @(negedge clk);
      if (load_done) seen = 1'b1;
    end
    checkOutput({name, " load_done seen"}, 32'(seen), 32'd1);
  endtask

  task automatic waitLogSize(input string name, input int n, input int max_cycles);
    logic reached;
    reached = 1'b0;
    for (int i = 0; i < max_cycles && !reached; i++) begin
      @(negedge clk);
      if (wr_log.size() >= n) reached = 1'b1;
    end
    checkOutput({name, " write progress"}, 32'(reached), 32'd1);
  endtask

  task automatic checkLog(input string name, input logic [47:0] exp_bytes);
    logic [7:0] exp_addr[6];
    exp_addr = '{8'h20, 8'h21, 8'h23, 8'h24, 8'h25, 8'h26};
    checkOutput({name, " write count"}, 32'(wr_log.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < wr_log.size())
        checkOutput($sformatf("%s write%0d", name, i), 32'(wr_log[i]),
                    32'({exp_addr[i], exp_bytes[47-8*i -: 8]}));
    end
  endtask

  // mode 0 releases reset instead of changing the enum.
  task automatic runPreset(input string name, input logic [3:0] en, input logic [15:0] th,
                           input logic [15:0] tm, input logic [47:0] exp_bytes,
                           input logic exp_clamped, input int mode);
    int start;
    wr_log.delete();
    start = done_count;
    if (mode == 0) begin
      @(negedge clk);
      rst = 1'b0;
    end else begin
      applyStimulus(en, th, tm);
    end
    waitLoadDone(name, 400);
    checkLog(name, exp_bytes);
    checkOutput({name, " clamped"}, 32'(clamped), 32'(exp_clamped));
    checkOutput({name, " loaded_enum"}, 32'(loaded_enum), 32'(en));
    repeat (8) @(negedge clk);
    checkOutput({name, " load_done pulses"}, 32'(done_count - start), 32'd1);
    checkOutput({name, " idle busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [7:0]  a0;
    logic [7:0]  d0;
    logic        stable;
    logic [3:0]  cur_enum;
    logic [3:0]  en;
    logic [15:0] th;
    logic [15:0] tm;
    int          start;

    n_checks     = 0;
    n_fail       = 0;
    done_delay   = 3;
    rst          = 1'b1;
    wr_ready     = 1'b1;
    spur_done    = 1'b0;
    value_enum   = 4'd0;
    value_thresh = 16'd300;
    value_timer  = 16'd1000;

    vecs[0] = '{4'd0,  16'd300,   16'd1000,   48'h2C_01_2C_01_E8_03, 1'b0};
    vecs[1] = '{4'd3,  16'd65000, 16'h1234,   48'hFF_07_FF_07_34_12, 1'b1};
    vecs[2] = '{4'd5,  16'd100,   16'h0000,   48'h64_00_64_00_00_00, 1'b0};
    vecs[3] = '{4'd9,  16'd2047,  16'hFFFF,   48'hFF_07_FF_07_FF_FF, 1'b0};
    vecs[4] = '{4'd10, 16'd2048,  16'h0100,   48'hFF_07_FF_07_00_01, 1'b1};
    vecs[5] = '{4'd15, 16'h0555,  16'hABCD,   48'h55_05_55_05_CD_AB, 1'b0};

    repeat (3) @(negedge clk);
    checkOutput("reset valid", 32'(wr_valid), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset addr/data", 32'({wr_addr, wr_data}), 32'd0);
    checkOutput("reset load_done", 32'(load_done), 32'd0);
    checkOutput("reset loaded_enum/clamped", 32'({loaded_enum, clamped}), 32'd0);

    for (int i = 0; i < 6; i++)
      runPreset($sformatf("vec%0d", i), vecs[i].en, vecs[i].thresh, vecs[i].timer,
                vecs[i].exp_bytes, vecs[i].exp_clamped, (i == 0) ? 0 : 1);

    // Latency, spurious done in ISSUE and backpressure.
    wr_log.delete();
    start = done_count;
    @(posedge clk);
    #1 wr_ready = 1'b0;
    applyStimulus(4'd7, 16'd1500, 16'h0BB8);
    @(negedge clk);
    checkOutput("latency k busy", 32'(busy), 32'd0);
    @(negedge clk);
    checkOutput("latency k+1 latch", 32'({busy, wr_valid}), 32'b10);
    @(negedge clk);
    checkOutput("latency k+2 valid", 32'(wr_valid), 32'd1);
    a0 = wr_addr;
    d0 = wr_data;
    checkOutput("bp first addr/data", 32'({a0, d0}), 32'({8'h20, modelBytes(16'd1500, 16'h0BB8)[47:40]}));
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!(wr_valid === 1'b1 && wr_addr === a0 && wr_data === d0)) stable = 1'b0;
    end
    checkOutput("bp hold stable", 32'(stable), 32'd1);
    checkOutput("bp no transfer", 32'(wr_log.size()), 32'd0);
    @(posedge clk);
    #1 wr_ready = 1'b1;
    waitLoadDone("bp", 400);
    checkLog("bp", modelBytes(16'd1500, 16'h0BB8));
    checkOutput("bp loaded_enum", 32'(loaded_enum), 32'd7);
    repeat (8) @(negedge clk);
    checkOutput("bp load_done pulses", 32'(done_count - start), 32'd1);

    // Spurious done while idle.
    start = done_count;
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("spur idle busy/valid", 32'({busy, wr_valid}), 32'd0);
    checkOutput("spur idle no load", 32'(done_count - start), 32'd0);

    // Preset changes during write 2 collapse into one reload.
    wr_log.delete();
    start = done_count;
    applyStimulus(4'd0, 16'd800, 16'd2000);
    waitLogSize("mid", 3, 200);
    applyStimulus(4'd1, 16'd3000, 16'd111);
    applyStimulus(4'd2, 16'd1234, 16'd4321);
    waitLoadDone("mid first", 400);
    checkLog("mid first", modelBytes(16'd800, 16'd2000));
    checkOutput("mid first loaded_enum", 32'(loaded_enum), 32'd0);
    wr_log.delete();
    waitLoadDone("mid reload", 400);
    checkLog("mid reload", modelBytes(16'd1234, 16'd4321));
    checkOutput("mid reload loaded_enum", 32'(loaded_enum), 32'd2);
    repeat (40) @(negedge clk);
    checkOutput("mid load_done pulses", 32'(done_count - start), 32'd2);

    // Asynchronous reset during write 3.
    wr_log.delete();
    applyStimulus(4'd0, 16'd5000, 16'h2710);
    waitLogSize("arst", 4, 200);
    @(posedge clk);
    #10 rst = 1'b1;
    #1;
    checkOutput("arst valid/busy/done", 32'({wr_valid, busy, load_done}), 32'd0);
    checkOutput("arst addr/data", 32'({wr_addr, wr_data}), 32'd0);
    checkOutput("arst loaded_enum/clamped", 32'({loaded_enum, clamped}), 32'd0);
    repeat (10) @(negedge clk);
    runPreset("arst reload", 4'd0, 16'd5000, 16'h2710, modelBytes(16'd5000, 16'h2710), 1'b1, 0);
    repeat (20) @(negedge clk);

    // Randomized presets against the model.
    cur_enum = 4'd0;
    for (int i = 0; i < 24; i++) begin
      en = cur_enum ^ 4'($urandom_range(1, 15));
      if ($urandom_range(0, 1) == 1) th = 16'($urandom_range(0, 4095));
      else                           th = 16'($urandom);
      tm = 16'($urandom);
      done_delay = $urandom_range(1, 4);
      runPreset($sformatf("rand%0d", i), en, th, tm, modelBytes(th, tm), (th > 16'd2047), 1);
      cur_enum = en;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
